// File: rtl/rally_flow_ctrl_pkg.sv
// Shared match-flow definitions: game-state encoding seen by the ball stage,
// court geometry and side encoding.
package rally_flow_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_START     = 2'd0,
    ST_WAIT_DROP = 2'd1,
    ST_IN_GAME   = 2'd2,
    ST_GAME_END  = 2'd3
  } game_state_e;

  localparam int VBUF_H  = 240;
  localparam int BALL_W  = 30;
  localparam int BALL_H  = 30;
  localparam int NET_X   = 160;
  localparam int NET_W   = 6;
  localparam int FLOOR_Y = VBUF_H - 20;

  localparam logic SIDE_PLAYER = 1'b0;
  localparam logic SIDE_NPC    = 1'b1;

endpackage

// File: rtl/rally_score_counter.sv
// One side's score: 4-bit counter with clear and increment, plus a flag that
// says the next increment reaches the winning score.
module rally_score_counter #(
  parameter int WIN_SCORE = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [3:0] cnt_o,
  output logic       win_next_o
);

  logic [3:0] cnt_q, cnt_d;

  // Next count: clear takes priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 4'd1;
  end

  // Score register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o      = cnt_q;
  // Computed at 5 bits so a WIN_SCORE of 15 compares without wrap.
  assign win_next_o = ({1'b0, cnt_q} + 5'd1) == 5'(WIN_SCORE);

endmodule

// File: rtl/rally_flow_ctrl.sv
// Match-flow controller: serve wait, landing detection, point award, score
// tracking and match end. All outputs come straight from registers.
module rally_flow_ctrl
  import rally_flow_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 50_000_000,
  parameter int ARM_CYCLES  = 2,
  parameter int WIN_SCORE   = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_btn,
  input  logic [11:0] Ball_X,
  input  logic [11:0] Ball_Y,
  output logic [1:0]  Game_state,
  output logic        who_win,
  output logic [3:0]  player_score,
  output logic [3:0]  npc_score,
  output logic        point_pulse,
  output logic        match_winner
);

  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int ARM_W  = (ARM_CYCLES > 0) ? $clog2(ARM_CYCLES + 1) : 1;

  game_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ARM_W-1:0]  arm_q, arm_d;
  logic              who_q, who_d;
  logic              win_q, win_d;
  logic              pulse_q, pulse_d;
  logic              start_q;

  logic        p_clr, p_inc, n_clr, n_inc;
  logic        p_win_next, n_win_next;
  logic [12:0] bottom, centre;
  logic        armed, landed, npc_half, start_rise;

  // Geometry is evaluated at 13 bits so large coordinates never wrap.
  assign bottom     = {1'b0, Ball_Y} + 13'(BALL_H);
  assign centre     = {1'b0, Ball_X} + 13'(BALL_W / 2);
  assign npc_half   = centre < 13'(NET_X + NET_W / 2);
  assign armed      = (arm_q == ARM_W'(ARM_CYCLES));
  assign landed     = armed && (bottom >= 13'(FLOOR_Y));
  assign start_rise = start_btn & ~start_q;

  rally_score_counter #(.WIN_SCORE(WIN_SCORE)) u_player (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (p_clr),
    .inc_i      (p_inc),
    .cnt_o      (player_score),
    .win_next_o (p_win_next)
  );

  rally_score_counter #(.WIN_SCORE(WIN_SCORE)) u_npc (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (n_clr),
    .inc_i      (n_inc),
    .cnt_o      (npc_score),
    .win_next_o (n_win_next)
  );

  // Next-state and point logic; a landing leaves IN_GAME in the same cycle,
  // so a held landing can only ever score once.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    arm_d   = arm_q;
    who_d   = who_q;
    win_d   = win_q;
    pulse_d = 1'b0;
    p_clr   = 1'b0;
    p_inc   = 1'b0;
    n_clr   = 1'b0;
    n_inc   = 1'b0;
    case (state_q)
      ST_START, ST_GAME_END: begin
        if (start_rise) begin
          state_d = ST_WAIT_DROP;
          wait_d  = '0;
          who_d   = SIDE_PLAYER;
          p_clr   = 1'b1;
          n_clr   = 1'b1;
        end
      end
      ST_WAIT_DROP: begin
        if (wait_q == WAIT_W'(WAIT_CYCLES - 1)) begin
          state_d = ST_IN_GAME;
          wait_d  = '0;
          arm_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_IN_GAME: begin
        if (!armed) arm_d = arm_q + 1'b1;
        if (landed) begin
          pulse_d = 1'b1;
          if (npc_half) begin
            p_inc = 1'b1;
            who_d = SIDE_PLAYER;
          end else begin
            n_inc = 1'b1;
            who_d = SIDE_NPC;
          end
          if (npc_half ? p_win_next : n_win_next) begin
            state_d = ST_GAME_END;
            win_d   = npc_half ? SIDE_PLAYER : SIDE_NPC;
          end else begin
            state_d = ST_WAIT_DROP;
            wait_d  = '0;
          end
        end
      end
      default: state_d = ST_START;
    endcase
  end

  // State and output registers; start_q resets high so a button held
  // through reset does not register as a press.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_START;
      wait_q  <= '0;
      arm_q   <= '0;
      who_q   <= SIDE_PLAYER;
      win_q   <= SIDE_PLAYER;
      pulse_q <= 1'b0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      arm_q   <= arm_d;
      who_q   <= who_d;
      win_q   <= win_d;
      pulse_q <= pulse_d;
      start_q <= start_btn;
    end
  end

  assign Game_state   = state_q;
  assign who_win      = who_q;
  assign point_pulse  = pulse_q;
  assign match_winner = win_q;

endmodule

// File: tb/tb_rally_flow_ctrl.sv
// Directed plus randomized rallies against a rally-level model of the match
// rules (arming, side decision, scoring, match end, serve dwell).
module tb_rally_flow_ctrl;

  localparam int WAIT = 4;
  localparam int ARM  = 2;
  localparam int WIN  = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_btn;
  logic [11:0] Ball_X, Ball_Y;
  logic [1:0]  Game_state;
  logic        who_win;
  logic [3:0]  player_score, npc_score;
  logic        point_pulse, match_winner;

  int total = 0;
  int bad   = 0;

  // Model state, tracked per rally.
  int exp_state, exp_p, exp_n, exp_who, exp_mw;
  int ig;  // IN_GAME cycles elapsed since entry

  rally_flow_ctrl #(.WAIT_CYCLES(WAIT), .ARM_CYCLES(ARM), .WIN_SCORE(WIN)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_btn    (start_btn),
    .Ball_X       (Ball_X),
    .Ball_Y       (Ball_Y),
    .Game_state   (Game_state),
    .who_win      (who_win),
    .player_score (player_score),
    .npc_score    (npc_score),
    .point_pulse  (point_pulse),
    .match_winner (match_winner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"}, 32'(Game_state), exp_state);
    chk({tag, ".pscore"}, 32'(player_score), exp_p);
    chk({tag, ".nscore"}, 32'(npc_score), exp_n);
    chk({tag, ".who"}, 32'(who_win), exp_who);
  endtask

  // Falling then rising start button; from START or GAME_END this opens a match.
  task automatic press();
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    exp_state = 1; exp_p = 0; exp_n = 0; exp_who = 0;
    chk_all("press");
  endtask

  // Measure WAIT_DROP dwell; no point may be awarded while waiting.
  task automatic serve_wait();
    int n = 0;
    while (Game_state !== 2'd2 && n < 20) begin
      chk("wait_pulse", 32'(point_pulse), (n == 0) ? 32'(point_pulse) : 32'd0);
      tick();
      n++;
    end
    chk("dwell", n, WAIT);
    exp_state = 2;
    ig = 0;
    chk_all("serve");
  endtask

  // d quiet cycles in flight, then one cycle with the ball at (x,y).
  task automatic rally(input int x, input int y, input int d);
    bit pt;
    int side;
    Ball_X = 12'(x);
    Ball_Y = 12'd50;
    for (int i = 0; i < d; i++) begin
      tick();
      ig++;
      chk("flight_pulse", 32'(point_pulse), 0);
    end
    Ball_X = 12'(x);
    Ball_Y = 12'(y);
    pt = (ig >= ARM) && (y + 30 >= 220);
    tick();
    ig++;
    if (pt) begin
      side = (x + 15 < 163) ? 0 : 1;
      if (side == 0) exp_p++; else exp_n++;
      exp_who = side;
      if ((side == 0 ? exp_p : exp_n) == WIN) begin
        exp_state = 3;
        exp_mw    = side;
      end else begin
        exp_state = 1;
      end
    end
    chk("pulse", 32'(point_pulse), pt ? 1 : 0);
    chk_all("rally");
    if (exp_state == 3) chk("winner", 32'(match_winner), exp_mw);
  endtask

  initial begin
    reset_n   = 1'b0;
    start_btn = 1'b1;
    Ball_X    = 12'd0;
    Ball_Y    = 12'd0;
    exp_state = 0; exp_p = 0; exp_n = 0; exp_who = 0; exp_mw = 0; ig = 0;

    // Reset with the button held; release must not start a match.
    repeat (3) tick();
    chk_all("reset");
    chk("reset.pulse", 32'(point_pulse), 0);
    chk("reset.mw", 32'(match_winner), 0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("held_btn.state", 32'(Game_state), 0);

    // First match: directed rallies.
    press();
    serve_wait();
    rally(40, 190, 2);        // bottom exactly on floor, player half
    serve_wait();             // landing held through the wait: no re-score
    rally(148, 195, 2);       // centre 163: NPC point
    serve_wait();
    rally(147, 195, 0);       // unarmed landing on entry cycle: ignored
    rally(147, 195, 1);       // centre 162, now armed: player point
    serve_wait();
    rally(100, 189, 3);       // bottom 219: not a landing
    rally(10, 200, 0);        // player reaches 3
    repeat (3) tick();
    chk_all("frozen");
    chk("frozen.mw", 32'(match_winner), 0);
    chk("frozen.pulse", 32'(point_pulse), 0);

    // Second match: randomized rallies with centres around the net.
    press();
    serve_wait();
    for (int r = 0; r < 60 && exp_state != 3; r++) begin
      rally($urandom_range(130, 175), $urandom_range(180, 400), $urandom_range(0, 3));
      if (exp_state == 1) begin
        start_btn = 1'b1;     // a press while waiting is ignored
        serve_wait();
        start_btn = 1'b0;
      end
    end
    chk("rand.ended", exp_state, 3);

    // Reset mid-wait after a point: no score retention.
    press();
    serve_wait();
    rally(40, 200, 2);
    tick();
    reset_n = 1'b0;
    tick();
    exp_state = 0; exp_p = 0; exp_n = 0; exp_who = 0;
    chk_all("midreset");
    chk("midreset.pulse", 32'(point_pulse), 0);
    chk("midreset.mw", 32'(match_winner), 0);
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
